// File: rtl/image_block_writer.sv
`default_nettype none
// ============================================================================
// Module   : image_block_writer
// Purpose  : Writes each encrypted 2x2 submatrix into frame memory in raster
//            block order and acknowledges upstream; FRAME_CHECKSUM_EN adds an
//            XOR checksum of captured blocks.
// Revision : 1.0 - initial release
// ============================================================================
module image_block_writer #(
    parameter int IMG_W  = 160,
    parameter int IMG_H  = 120,
    parameter int ADDR_W = 15
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic              readyToBeProcessed,
    input  logic [15:0]       imageGeneratorInput,
    input  logic              frameStart,
    output logic              processed,
    output logic              wrEn,
    output logic [ADDR_W-1:0] wrAddr,
    output logic [3:0]        wrData,
    output logic              frameDone,
    output logic [15:0]       frameChecksum
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_WRITE = 3'd1;
    localparam logic [2:0] c_ACK   = 3'd2;
    localparam logic [2:0] c_DROP  = 3'd3;
    localparam logic [2:0] c_DONE  = 3'd4;

    localparam logic [ADDR_W-1:0] c_LAST_X = ADDR_W'(IMG_W - 2);
    localparam logic [ADDR_W-1:0] c_LAST_Y = ADDR_W'(IMG_H - 2);
    localparam logic [ADDR_W-1:0] c_ROW    = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] c_STEP   = ADDR_W'(2);

    logic [2:0]        r_state, w_state_n;
    logic [ADDR_W-1:0] r_bx, r_by, w_bx_n, w_by_n;
    logic [1:0]        r_idx, w_idx_n;
    logic [15:0]       r_data, w_data_n;
    logic              w_capture, w_restart;

    logic              w_wren_n, w_proc_n, w_done_n;
    logic [ADDR_W-1:0] w_addr_n;
    logic [3:0]        w_pix_n;

    logic              r_processed, r_wren, r_done;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_pix;

    // Outputs are registered from the next-state values so they line up with the state they describe
    always_ff @(posedge clock) begin
        if (!resetN) begin
            r_state     <= c_IDLE;
            r_bx        <= '0;
            r_by        <= '0;
            r_idx       <= 2'd0;
            r_data      <= 16'h0000;
            r_processed <= 1'b0;
            r_wren      <= 1'b0;
            r_addr      <= '0;
            r_pix       <= 4'h0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_bx        <= w_bx_n;
            r_by        <= w_by_n;
            r_idx       <= w_idx_n;
            r_data      <= w_data_n;
            r_processed <= w_proc_n;
            r_wren      <= w_wren_n;
            r_addr      <= w_addr_n;
            r_pix       <= w_pix_n;
            r_done      <= w_done_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_bx_n    = r_bx;
        w_by_n    = r_by;
        w_idx_n   = r_idx;
        w_capture = 1'b0;
        w_restart = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (frameStart) begin
                    w_restart = 1'b1;
                end else if (readyToBeProcessed) begin
                    w_capture = 1'b1;
                    w_idx_n   = 2'd0;
                    w_state_n = c_WRITE;
                end
            end
            c_WRITE: begin
                if (r_idx == 2'd3) begin
                    w_state_n = c_ACK;
                end else begin
                    w_idx_n = r_idx + 2'd1;
                end
            end
            c_ACK: begin
                if (r_bx == c_LAST_X) begin
                    w_bx_n = '0;
                    w_by_n = r_by + c_STEP;
                end else begin
                    w_bx_n = r_bx + c_STEP;
                end
                if (r_bx == c_LAST_X && r_by == c_LAST_Y) begin
                    w_by_n    = '0;
                    w_state_n = c_DONE;
                end else begin
                    w_state_n = c_DROP;
                end
            end
            c_DROP: begin
                // Block must be de-asserted before the next capture to avoid re-writing it
                if (!readyToBeProcessed) begin
                    w_state_n = c_IDLE;
                end
            end
            c_DONE: begin
                if (frameStart) begin
                    w_restart = 1'b1;
                end
            end
            default: begin
                w_state_n = c_IDLE;
            end
        endcase
        if (w_restart) begin
            w_bx_n    = '0;
            w_by_n    = '0;
            w_state_n = c_IDLE;
        end
    end

    assign w_data_n = w_capture ? imageGeneratorInput : r_data;

    always_comb begin
        w_wren_n = (w_state_n == c_WRITE);
        w_proc_n = (w_state_n == c_ACK);
        w_done_n = (w_state_n == c_DONE);
        w_addr_n = '0;
        w_pix_n  = 4'h0;
        if (w_wren_n) begin
            w_addr_n = w_by_n * c_ROW + w_bx_n + (w_idx_n[1] ? c_ROW : '0)
                     + {{(ADDR_W-1){1'b0}}, w_idx_n[0]};
            case (w_idx_n)
                2'd0:    w_pix_n = w_data_n[15:12];
                2'd1:    w_pix_n = w_data_n[11:8];
                2'd2:    w_pix_n = w_data_n[7:4];
                default: w_pix_n = w_data_n[3:0];
            endcase
        end
    end

    assign processed = r_processed;
    assign wrEn      = r_wren;
    assign wrAddr    = r_addr;
    assign wrData    = r_pix;
    assign frameDone = r_done;

`ifdef FRAME_CHECKSUM_EN
    logic [15:0] r_checksum;

    always_ff @(posedge clock) begin
        if (!resetN || w_restart) begin
            r_checksum <= 16'h0000;
        end else if (w_capture) begin
            r_checksum <= r_checksum ^ imageGeneratorInput;
        end
    end

    assign frameChecksum = r_checksum;
`else
    assign frameChecksum = 16'h0000;
`endif

endmodule
`default_nettype wire
